// File: rtl/gabor_conv3x3.sv
// gabor_conv3x3: programmable signed 3x3 Gabor kernel applied to a line-buffer window, one 8-bit pixel out per window.
// Latency: exactly 3 cycles from i_pixel_data_valid to o_pixel_data_valid; bubbles travel with the data.
// Backpressure: none; every valid window is accepted and produces exactly one output.
//
// Ports:
//   i_clk, i_rst_n             clock (rising edge), asynchronous active-low reset
//   i_pixel_data[71:0]         3x3 window, pixel k in bits [8k+7:8k], k=4 is the centre
//   i_pixel_data_valid         window valid
//   i_coef_wr/addr/data        write one signed coefficient into the shadow bank (addr 9..15 ignored)
//   i_coef_commit              copy the shadow bank into the active bank at the next edge
//   o_pixel_data[7:0]          filtered pixel, held while o_pixel_data_valid is low
//   o_pixel_data_valid         output valid
//   o_line_done                one-cycle pulse with the LINE_W-th output of each line
module gabor_conv3x3 #(
  parameter int LINE_W    = 512,
  parameter int OUT_SHIFT = 6,
  parameter int ABS_MODE  = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [71:0] i_pixel_data,
  input  logic        i_pixel_data_valid,
  input  logic        i_coef_wr,
  input  logic [3:0]  i_coef_addr,
  input  logic [7:0]  i_coef_data,
  input  logic        i_coef_commit,
  output logic [7:0]  o_pixel_data,
  output logic        o_pixel_data_valid,
  output logic        o_line_done
);

  localparam int CNT_W = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_W - 1);
  // Centre weight of 2**OUT_SHIFT makes the reset kernel a pass-through.
  // With OUT_SHIFT=7 this wraps to -128 since the coefficient is 8-bit signed.
  localparam logic signed [7:0]  CENTRE_INIT = 8'(1 << OUT_SHIFT);
  localparam logic signed [20:0] ROUND       = 21'(1 << (OUT_SHIFT - 1));

  logic signed [7:0]  coef_sh_q  [9];
  logic signed [7:0]  coef_sh_d  [9];
  logic signed [7:0]  coef_act_q [9];
  logic signed [7:0]  coef_act_d [9];

  logic               s1_vld_q, s1_vld_d;
  logic signed [16:0] prod_q [9];
  logic signed [16:0] prod_d [9];

  logic               s2_vld_q, s2_vld_d;
  logic signed [18:0] row_q [3];
  logic signed [18:0] row_d [3];

  logic               out_vld_q, out_vld_d;
  logic [7:0]         out_dat_q, out_dat_d;
  logic               line_done_q, line_done_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic signed [20:0] sum_w, rnd_w, q_w, mag_w;
  logic [7:0]         sat_w;

  // Commit reads the shadow bank as it stood before any same-cycle write,
  // so a write and a commit together leave the written value in shadow only.
  always_comb begin
    for (int k = 0; k < 9; k++) begin
      coef_sh_d[k]  = coef_sh_q[k];
      coef_act_d[k] = i_coef_commit ? coef_sh_q[k] : coef_act_q[k];
      if (i_coef_wr && (i_coef_addr == 4'(k))) begin
        coef_sh_d[k] = i_coef_data;
      end
    end
  end

  // S1: products use the active bank as registered, so a window arriving with a
  // commit still sees the old kernel.
  always_comb begin
    s1_vld_d = i_pixel_data_valid;
    for (int k = 0; k < 9; k++) begin
      prod_d[k] = $signed({9'b0, i_pixel_data[8*k +: 8]}) *
                  $signed({{9{coef_act_q[k][7]}}, coef_act_q[k]});
    end
  end

  // S2: one partial sum per window row.
  always_comb begin
    s2_vld_d = s1_vld_q;
    for (int r = 0; r < 3; r++) begin
      row_d[r] = {{2{prod_q[3*r][16]}},   prod_q[3*r]} +
                 {{2{prod_q[3*r+1][16]}}, prod_q[3*r+1]} +
                 {{2{prod_q[3*r+2][16]}}, prod_q[3*r+2]};
    end
  end

  // S3: total, round-half-up, arithmetic shift, fold negatives, saturate.
  always_comb begin
    sum_w = {{2{row_q[0][18]}}, row_q[0]} +
            {{2{row_q[1][18]}}, row_q[1]} +
            {{2{row_q[2][18]}}, row_q[2]};
    rnd_w = sum_w + ROUND;
    q_w   = rnd_w >>> OUT_SHIFT;
    if (q_w[20]) begin
      mag_w = (ABS_MODE != 0) ? -q_w : '0;
    end else begin
      mag_w = q_w;
    end
    sat_w = (mag_w > 21'sd255) ? 8'hFF : mag_w[7:0];

    out_vld_d   = s2_vld_q;
    out_dat_d   = s2_vld_q ? sat_w : out_dat_q;
    line_done_d = 1'b0;
    cnt_d       = cnt_q;
    if (s2_vld_q) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d       = '0;
        line_done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < 9; k++) begin
        coef_sh_q[k]  <= (k == 4) ? CENTRE_INIT : 8'sd0;
        coef_act_q[k] <= (k == 4) ? CENTRE_INIT : 8'sd0;
        prod_q[k]     <= '0;
      end
      for (int r = 0; r < 3; r++) begin
        row_q[r] <= '0;
      end
      s1_vld_q    <= 1'b0;
      s2_vld_q    <= 1'b0;
      out_vld_q   <= 1'b0;
      out_dat_q   <= '0;
      line_done_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      coef_sh_q   <= coef_sh_d;
      coef_act_q  <= coef_act_d;
      prod_q      <= prod_d;
      row_q       <= row_d;
      s1_vld_q    <= s1_vld_d;
      s2_vld_q    <= s2_vld_d;
      out_vld_q   <= out_vld_d;
      out_dat_q   <= out_dat_d;
      line_done_q <= line_done_d;
      cnt_q       <= cnt_d;
    end
  end

  assign o_pixel_data       = out_dat_q;
  assign o_pixel_data_valid = out_vld_q;
  assign o_line_done        = line_done_q;

endmodule

// File: tb/tb_gabor_conv3x3.sv
// tb_gabor_conv3x3: drives two gabor_conv3x3 instances (magnitude and clamp modes) from one stimulus stream
// and checks every cycle against an arithmetic model of the filter, coefficient banks and line counter.
`timescale 1ns/1ps
module tb_gabor_conv3x3;

  localparam int LINE_W = 512;
  localparam int SH     = 6;
  localparam logic [71:0] RST_BANK = 72'h40 << 32;

  logic        clk;
  logic        rst_n;
  logic [71:0] pix;
  logic        pix_vld;
  logic        wr;
  logic [3:0]  addr;
  logic [7:0]  cdat;
  logic        commit;
  logic [7:0]  o_a, o_c;
  logic        v_a, v_c, ld_a, ld_c;

  gabor_conv3x3 #(.LINE_W(LINE_W), .OUT_SHIFT(SH), .ABS_MODE(1)) u_dut_abs (
    .i_clk(clk), .i_rst_n(rst_n), .i_pixel_data(pix), .i_pixel_data_valid(pix_vld),
    .i_coef_wr(wr), .i_coef_addr(addr), .i_coef_data(cdat), .i_coef_commit(commit),
    .o_pixel_data(o_a), .o_pixel_data_valid(v_a), .o_line_done(ld_a)
  );

  gabor_conv3x3 #(.LINE_W(LINE_W), .OUT_SHIFT(SH), .ABS_MODE(0)) u_dut_clp (
    .i_clk(clk), .i_rst_n(rst_n), .i_pixel_data(pix), .i_pixel_data_valid(pix_vld),
    .i_coef_wr(wr), .i_coef_addr(addr), .i_coef_data(cdat), .i_coef_commit(commit),
    .o_pixel_data(o_c), .o_pixel_data_valid(v_c), .o_line_done(ld_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int model_sum(input logic [71:0] w, input logic [71:0] cv);
    int s;
    s = 0;
    for (int k = 0; k < 9; k++) begin
      s += int'(w[8*k +: 8]) * int'($signed(cv[8*k +: 8]));
    end
    return s;
  endfunction

  // Round half up then floor-divide by 2**SH.
  function automatic int model_q(input logic [71:0] w, input logic [71:0] cv);
    int r, d;
    d = 1 << SH;
    r = model_sum(w, cv) + d / 2;
    if (r >= 0) return r / d;
    return -((-r + d - 1) / d);
  endfunction

  function automatic int model_px(input logic [71:0] w, input logic [71:0] cv, input bit absm);
    int q;
    q = model_q(w, cv);
    if (q < 0) q = absm ? -q : 0;
    if (q > 255) q = 255;
    return q;
  endfunction

  int          cyc = 0;
  bit          exp_v  [16];
  bit          exp_ld [16];
  int          exp_a  [16];
  int          exp_c  [16];
  logic [71:0] m_sh, m_act;
  int          m_cnt;

  // Model updates at each rising edge from the inputs the DUT samples there.
  initial begin
    int s;
    m_sh  = RST_BANK;
    m_act = RST_BANK;
    m_cnt = 0;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      if (!rst_n) begin
        for (int i = 0; i < 16; i++) exp_v[i] = 1'b0;
        m_sh  = RST_BANK;
        m_act = RST_BANK;
        m_cnt = 0;
      end else begin
        if (pix_vld) begin
          s = (cyc + 2) % 16;
          exp_v[s] = 1'b1;
          exp_a[s] = model_px(pix, m_act, 1'b1);
          exp_c[s] = model_px(pix, m_act, 1'b0);
          m_cnt++;
          exp_ld[s] = (m_cnt == LINE_W);
          if (m_cnt == LINE_W) m_cnt = 0;
        end
        if (commit) m_act = m_sh;
        if (wr && addr < 4'd9) m_sh[int'(addr)*8 +: 8] = cdat;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int last_a = 0;
  int last_c = 0;
  int out_cnt = 0;
  int ld_cnt = 0;
  int ld_pos [4];

  initial begin
    int slot;
    forever begin
      @(negedge clk);
      slot = cyc % 16;
      if (!rst_n) begin
        chk("rst_vld_a", int'(v_a), 0);
        chk("rst_vld_c", int'(v_c), 0);
        chk("rst_dat_a", int'(o_a), 0);
        chk("rst_dat_c", int'(o_c), 0);
        chk("rst_ld_a", int'(ld_a), 0);
        chk("rst_ld_c", int'(ld_c), 0);
        last_a = 0;
        last_c = 0;
        exp_v[slot] = 1'b0;
      end else begin
        chk("vld_a", int'(v_a), int'(exp_v[slot]));
        chk("vld_c", int'(v_c), int'(exp_v[slot]));
        chk("ld_a", int'(ld_a), int'(exp_v[slot] & exp_ld[slot]));
        chk("ld_c", int'(ld_c), int'(exp_v[slot] & exp_ld[slot]));
        if (exp_v[slot]) begin
          chk("dat_a", int'(o_a), exp_a[slot]);
          chk("dat_c", int'(o_c), exp_c[slot]);
          last_a = exp_a[slot];
          last_c = exp_c[slot];
        end else begin
          chk("hold_a", int'(o_a), last_a);
          chk("hold_c", int'(o_c), last_c);
        end
        if (v_a) begin
          out_cnt++;
          if (ld_a) begin
            if (ld_cnt < 4) ld_pos[ld_cnt] = out_cnt;
            ld_cnt++;
          end
        end
        exp_v[slot] = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pix_vld = 1'b0;
    wr      = 1'b0;
    commit  = 1'b0;
  endtask

  function automatic logic [71:0] rnd72();
    return {8'($urandom), 32'($urandom), 32'($urandom)};
  endfunction

  function automatic logic [71:0] win_c(input logic [7:0] c);
    logic [71:0] w;
    w = rnd72();
    w[39:32] = c;
    return w;
  endfunction

  task automatic wr_coef(input int a, input logic [7:0] d);
    wr   = 1'b1;
    addr = 4'(a);
    cdat = d;
    tick();
    wr = 1'b0;
  endtask

  task automatic load_bank(input logic [71:0] cv);
    for (int k = 0; k < 9; k++) wr_coef(k, cv[8*k +: 8]);
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  // Single isolated window; its result must appear exactly 3 cycles later.
  task automatic send_chk(input logic [71:0] w, input int ea, input int ec, input string name);
    pix_vld = 1'b1;
    pix     = w;
    tick();
    pix_vld = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk({name, "_vld"}, int'(v_a), 1);
    chk({name, "_a"}, int'(o_a), ea);
    chk({name, "_c"}, int'(o_c), ec);
    tick();
  endtask

  task automatic rand_stream(input int n, input int pct, input bit churn);
    for (int i = 0; i < n; i++) begin
      pix_vld = ($urandom_range(99) < pct);
      pix     = rnd72();
      if (churn) begin
        wr     = ($urandom_range(3) == 0);
        addr   = 4'($urandom_range(15));
        cdat   = 8'($urandom);
        commit = ($urandom_range(7) == 0);
      end
      tick();
    end
    idle();
  endtask

  task automatic line_check(input string name);
    chk({name, "_pulses"}, ld_cnt, 2);
    chk({name, "_pos0"}, ld_pos[0], 512);
    chk({name, "_pos1"}, ld_pos[1], 1024);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [71:0] bank, w1, w2, ff, sev;
    int n;
    rst_n = 1'b1;
    idle();
    pix  = '0;
    addr = '0;
    cdat = '0;
    #1 rst_n = 1'b0;

    // Hand-computed values that pin the model.
    ff  = {9{8'hFF}};
    sev = {9{8'h7F}};
    chk("pin_sum", model_sum(ff, sev), 291465);
    chk("pin_q", model_q(ff, sev), 4554);
    chk("pin_sat", model_px(ff, sev, 1'b1), 255);
    bank = '0;
    bank[39:32] = 8'hC0;
    w1 = '0;
    w1[39:32] = 8'd100;
    chk("pin_neg_q", model_q(w1, bank), -100);
    chk("pin_neg_abs", model_px(w1, bank, 1'b1), 100);
    chk("pin_neg_clp", model_px(w1, bank, 1'b0), 0);
    w1 = win_c(8'hA5);
    chk("pin_pass", model_px(w1, RST_BANK, 1'b1), 165);

    repeat (3) tick();
    @(negedge clk);
    chk("reset_vld", int'(v_a), 0);
    chk("reset_dat", int'(o_a), 0);
    chk("reset_ld", int'(ld_a), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Pass-through after reset.
    send_chk(win_c(8'hA5), 165, 165, "pass_a5");
    send_chk(win_c(8'h3C), 60, 60, "pass_3c");
    rand_stream(200, 50, 1'b0);

    // Saturation.
    load_bank(sev);
    send_chk(ff, 255, 255, "sat");

    // Negative result: magnitude versus clamp.
    load_bank(bank);
    send_chk(win_c(8'd100), 100, 0, "neg");

    // Random kernels with writes and commits mixed into the stream.
    rand_stream(600, 60, 1'b1);

    // Shadow write without commit leaves the active kernel alone.
    load_bank(RST_BANK);
    wr_coef(4, 8'h00);
    rand_stream(50, 70, 1'b0);
    w1 = win_c(8'h5A);
    w2 = win_c(8'h33);
    pix_vld = 1'b1;
    pix     = w1;
    commit  = 1'b1;
    tick();
    commit = 1'b0;
    pix    = w2;
    tick();
    pix_vld = 1'b0;
    tick();
    @(negedge clk);
    chk("commit_old_vld", int'(v_a), 1);
    chk("commit_old_dat", int'(o_a), 90);
    tick();
    @(negedge clk);
    chk("commit_new_vld", int'(v_a), 1);
    chk("commit_new_dat", int'(o_a), 0);
    tick();

    // Line-done pulses: back-to-back, then with random gaps.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    out_cnt = 0;
    ld_cnt  = 0;
    pix_vld = 1'b1;
    repeat (1024) begin
      pix = rnd72();
      tick();
    end
    pix_vld = 1'b0;
    repeat (5) tick();
    line_check("line_b2b");

    out_cnt = 0;
    ld_cnt  = 0;
    n = 0;
    while (n < 1024) begin
      pix_vld = ($urandom_range(2) != 0);
      pix     = rnd72();
      if (pix_vld) n++;
      tick();
    end
    pix_vld = 1'b0;
    repeat (5) tick();
    line_check("line_gap");

    // Reset with windows in flight.
    load_bank({9{8'h11}});
    pix_vld = 1'b1;
    repeat (3) begin
      pix = rnd72();
      tick();
    end
    pix_vld = 1'b0;
    chk("midrst_pre_vld", int'(v_a), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_drop_a", int'(v_a), 0);
    chk("midrst_drop_c", int'(v_c), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("midrst_flush", int'(v_a), 0);
    end
    tick();
    send_chk(win_c(8'h77), 119, 119, "midrst_coef");

    rand_stream(150, 80, 1'b1);
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
